// File: rtl/polar_xy.sv
// polar_xy -- polar (amplitude, phase index) to Cartesian (x, y) converter.
//
// x = A*cos(theta), y = A*sin(theta). A, x and y are IEEE-754 single.
// theta = phase * 2*pi / 2^PHASE_W. One conversion takes 3 cycles after
// acceptance and runs through LOOKUP -> MUL -> NORM.
//
// Trig values come from a quarter-wave table of Q+1 entries, where
// Q = 2^(PHASE_W-2) and T[i] = |cos(i*pi/(2Q))|. Quadrant folding supplies
// the signs and the complementary index. The table is computed at
// elaboration by a constant function, so it needs no external image file.
// Entries are rounded to nearest. T[0] = 1.0 exactly and T[Q] = +0.
//
// Float multiply uses truncation. A zero or denormal operand, or a final
// exponent <= 0, gives +0. An infinite/NaN amplitude, or a final
// exponent >= 255, gives a signed infinity.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-high reset
//   start  in   conversion request
//   ampli  in   [31:0] amplitude, IEEE-754 single
//   phase  in   [PHASE_W-1:0] angle index over one full turn
//   x      out  [31:0] A*cos(theta)
//   y      out  [31:0] A*sin(theta)
//   done   out  1 = idle with x/y valid, 0 = busy
//
// Handshake: done=1 means idle, and x/y hold the last result. A conversion
// is accepted on any rising edge where done=1 and start=1. ampli and phase
// are captured on that edge and may change afterwards. done drops on the
// accepting edge and rises again 3 edges later, on the edge that updates
// x and y. start is ignored while done=0; it is not queued.

module polar_xy #(
  parameter int PHASE_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        ampli,
  input  logic [PHASE_W-1:0] phase,
  output logic [31:0]        x,
  output logic [31:0]        y,
  output logic               done
);

  localparam int Q  = 1 << (PHASE_W - 2);
  localparam int IW = PHASE_W - 1;          // index width covering 0..Q

  // pi in unsigned fixed point with 60 fractional bits
  localparam logic [127:0] PI_Q60 = 128'h3243F6A8885A308D;

  // Elaboration-time |cos(idx*pi/(2Q))| as IEEE-754 single, round to nearest.
  // Taylor series in 60-bit fixed point. Positive and negative terms are
  // accumulated separately, so all arithmetic stays unsigned.
  function automatic logic [31:0] cos_bits(input int idx);
    logic [127:0] ang;
    logic [127:0] ang2;
    logic [127:0] term;
    logic [127:0] pos;
    logic [127:0] neg;
    logic [127:0] val;
    logic [127:0] m;
    logic [7:0]   e;
    int           lead;
    int           sh;
    if (idx >= Q) return 32'd0;
    ang  = (PI_Q60 * 128'(idx)) >> (PHASE_W - 1);
    ang2 = (ang * ang) >> 60;
    term = 128'd1 << 60;
    pos  = term;
    neg  = 128'd0;
    for (int k = 1; k <= 16; k++) begin
      term = ((term * ang2) >> 60) / 128'((2 * k - 1) * (2 * k));
      if ((k % 2) == 1) neg = neg + term;
      else              pos = pos + term;
    end
    val = pos - neg;
    if (val == 128'd0) return 32'd0;
    lead = 0;
    for (int b = 0; b < 64; b++) begin
      if (val[b]) lead = b;
    end
    sh = lead - 23;
    m  = val >> sh;
    m  = m + ((val >> (sh - 1)) & 128'd1);
    if (m >= (128'd1 << 24)) begin
      m    = m >> 1;
      lead = lead + 1;
    end
    e = 8'(lead + 67);                      // lead - 60 + 127
    return {1'b0, e, m[22:0]};
  endfunction

  logic [31:0] rom [0:Q];

  for (genvar i = 0; i <= Q; i++) begin : g_rom
    localparam logic [31:0] TV = cos_bits(i);
    assign rom[i] = TV;
  end

  // Truncating normalisation of one 1.xx * 1.xx product (top 25 bits only).
  function automatic logic [31:0] norm_f(input logic [24:0]       p_hi,
                                         input logic signed [9:0] e_raw,
                                         input logic              sgn,
                                         input logic              zero_op,
                                         input logic              inf_op);
    logic signed [9:0] e;
    logic [22:0]       m;
    e = e_raw + (p_hi[24] ? 10'sd1 : 10'sd0);
    m = p_hi[24] ? p_hi[23:1] : p_hi[22:0];
    if (zero_op)            return 32'h0000_0000;
    else if (inf_op)        return {sgn, 8'hFF, 23'd0};
    else if (e <= 10'sd0)   return 32'h0000_0000;
    else if (e >= 10'sd255) return {sgn, 8'hFF, 23'd0};
    else                    return {sgn, e[7:0], m};
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MUL    = 2'd2,
    NORM   = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOOKUP;
      LOOKUP:  state_nx = MUL;
      MUL:     state_nx = NORM;
      NORM:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign done = (state == IDLE);

  // Captured operands
  logic [31:0]        amp_q;
  logic [PHASE_W-1:0] ph_q;

  // Lookup stage
  logic [31:0] cmag_q;
  logic [31:0] smag_q;
  logic        csgn_q;
  logic        ssgn_q;

  // Multiply stage
  logic [47:0]       px_q;
  logic [47:0]       py_q;
  logic signed [9:0] ex_q;
  logic signed [9:0] ey_q;
  logic              sx_q;
  logic              sy_q;
  logic              zx_q;
  logic              zy_q;
  logic              inf_q;

  // Quadrant folding: odd quadrants swap which index reads cos and which
  // reads sin. Q-r spans 1..Q, so the index needs one bit more than r.
  logic [1:0]    quad;
  logic [IW-1:0] rem;
  logic [IW-1:0] rem_c;
  logic [IW-1:0] c_idx;
  logic [IW-1:0] s_idx;
  logic [31:0]   tab_c;
  logic [31:0]   tab_s;

  always_comb begin
    quad  = ph_q[PHASE_W-1:PHASE_W-2];
    rem   = {1'b0, ph_q[PHASE_W-3:0]};
    rem_c = IW'(Q) - rem;
    c_idx = quad[0] ? rem_c : rem;
    s_idx = quad[0] ? rem   : rem_c;
    tab_c = rom[c_idx];
    tab_s = rom[s_idx];
  end

  logic [47:0]       prod_x;
  logic [47:0]       prod_y;
  logic signed [9:0] exr_x;
  logic signed [9:0] exr_y;

  always_comb begin
    prod_x = {1'b1, amp_q[22:0]} * {1'b1, cmag_q[22:0]};
    prod_y = {1'b1, amp_q[22:0]} * {1'b1, smag_q[22:0]};
    exr_x  = $signed({2'b00, amp_q[30:23]}) + $signed({2'b00, cmag_q[30:23]}) - 10'sd127;
    exr_y  = $signed({2'b00, amp_q[30:23]}) + $signed({2'b00, smag_q[30:23]}) - 10'sd127;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      amp_q  <= '0;
      ph_q   <= '0;
      cmag_q <= '0;
      smag_q <= '0;
      csgn_q <= 1'b0;
      ssgn_q <= 1'b0;
      px_q   <= '0;
      py_q   <= '0;
      ex_q   <= '0;
      ey_q   <= '0;
      sx_q   <= 1'b0;
      sy_q   <= 1'b0;
      zx_q   <= 1'b0;
      zy_q   <= 1'b0;
      inf_q  <= 1'b0;
      x      <= '0;
      y      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            amp_q <= ampli;
            ph_q  <= phase;
          end
        end
        LOOKUP: begin
          cmag_q <= tab_c;
          smag_q <= tab_s;
          csgn_q <= quad[1] ^ quad[0];      // cos < 0 in quadrants 1, 2
          ssgn_q <= quad[1];                // sin < 0 in quadrants 2, 3
        end
        MUL: begin
          px_q  <= prod_x;
          py_q  <= prod_y;
          ex_q  <= exr_x;
          ey_q  <= exr_y;
          sx_q  <= amp_q[31] ^ csgn_q;
          sy_q  <= amp_q[31] ^ ssgn_q;
          zx_q  <= (amp_q[30:23] == 8'd0) || (cmag_q[30:23] == 8'd0);
          zy_q  <= (amp_q[30:23] == 8'd0) || (smag_q[30:23] == 8'd0);
          inf_q <= (amp_q[30:23] == 8'hFF);
        end
        NORM: begin
          x <= norm_f(px_q[47:23], ex_q, sx_q, zx_q, inf_q);
          y <= norm_f(py_q[47:23], ey_q, sy_q, zy_q, inf_q);
        end
        default: ;
      endcase
    end
  end

  // Product bits below the truncation point and the always-zero table sign
  // bits are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{px_q[22:0], py_q[22:0], cmag_q[31], smag_q[31]};

endmodule
